// File: rtl/button_scan_debouncer.sv
// Multi-button debouncer: one shared sample prescaler and scan sequencer
// time-share N per-button stability counters and feed an event FIFO.

module button_scan_lane #(
    parameter int STABLE_TICKS = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic svc,
    input  logic smp,
    output logic deb,
    output logic accept
);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [CW-1:0] cnt;

    assign accept = svc && (smp != deb) && (cnt == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (svc) begin
            if (smp == deb) begin
                cnt <= '0;
            end else if (accept) begin
                deb <= smp;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module button_scan_debouncer #(
    parameter int N_BTN        = 4,
    parameter int TICK_CYCLES  = 100_000,
    parameter int STABLE_TICKS = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_BTN-1:0]         noisy,
    output logic [N_BTN-1:0]         debounced,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_btn,
    output logic                     evt_press,
    output logic                     evt_overflow
);
    localparam int BW = $clog2(N_BTN);
    localparam int PW = $clog2(TICK_CYCLES);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [BW-1:0] btn;
        logic          press;
    } evt_t;

    typedef enum logic {IDLE, SCAN} state_t;

    logic [N_BTN-1:0] meta, sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= noisy;
            sync <= meta;
        end
    end

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pcnt <= '0;
        else          pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    state_t        state;
    logic [BW-1:0] idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    state <= SCAN;
                    idx   <= '0;
                end
                SCAN: if (idx == BW'(N_BTN - 1)) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the lane selected by idx can accept, so idx names the event source.
    logic [N_BTN-1:0] accept;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        button_scan_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .svc    (state == SCAN && idx == BW'(i)),
            .smp    (sync[i]),
            .deb    (debounced[i]),
            .accept (accept[i])
        );
    end

    evt_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] count;
    logic          push, pop, full, push_ok;
    evt_t          push_evt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push      = |accept;
    assign push_evt  = '{btn: idx, press: sync[idx]};
    assign evt_valid = (count != '0);
    assign full      = (count == FW'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = push && (!full || pop);
    assign evt_btn   = mem[rd_ptr].btn;
    assign evt_press = mem[rd_ptr].press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_evt;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            evt_overflow <= push && !push_ok;
        end
    end
endmodule

// File: tb/tb_button_scan_debouncer.sv
// Bench for button_scan_debouncer: directed scenarios plus random stimulus
// against a cycle-scheduled model of sample times and an event queue.

module tb_button_scan_debouncer;
    localparam int N = 4, T = 10, S = 4, D = 4;

    logic         clk = 1'b0, reset_n = 1'b1;
    logic [N-1:0] noisy = '0;
    logic [N-1:0] debounced;
    logic         evt_valid, evt_ready = 1'b1;
    logic [1:0]   evt_btn;
    logic         evt_press, evt_overflow;

    int checks = 0, errors = 0;

    typedef struct packed {
        logic [1:0] b;
        logic       p;
    } ev_t;

    button_scan_debouncer #(
        .N_BTN(N), .TICK_CYCLES(T), .STABLE_TICKS(S), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset_n(reset_n), .noisy(noisy), .debounced(debounced),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
        .evt_press(evt_press), .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    // Model: edge e after reset release samples button i when e = k*T + i + 1, k >= 1.
    int           e = 0;
    logic [N-1:0] ms1 = '0, ms2 = '0, mdeb = '0;
    int           mcnt [N];
    ev_t          mq [$];
    logic         mov = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        forever begin : model
            logic pop, pushv;
            ev_t  pe;
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                e = 0; ms1 = '0; ms2 = '0; mdeb = '0; mov = 1'b0;
                mq.delete();
                for (int i = 0; i < N; i++) mcnt[i] = 0;
            end else begin
                e++;
                pop   = (mq.size() > 0) && evt_ready;
                pushv = 1'b0;
                pe    = '0;
                for (int i = 0; i < N; i++) begin
                    if (e >= T + i + 1 && (e - i - 1) % T == 0) begin
                        if (ms2[i] == mdeb[i]) mcnt[i] = 0;
                        else if (mcnt[i] + 1 == S) begin
                            mdeb[i] = ms2[i]; mcnt[i] = 0;
                            pushv = 1'b1; pe.b = 2'(i); pe.p = ms2[i];
                        end else mcnt[i]++;
                    end
                end
                if (pop) void'(mq.pop_front());
                mov = 1'b0;
                if (pushv) begin
                    if (mq.size() < D) mq.push_back(pe);
                    else mov = 1'b1;
                end
                ms2 = ms1; ms1 = noisy;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            checks++;
            if (debounced !== mdeb) begin
                errors++; $display("FAIL model_debounced got=%b exp=%b t=%0t", debounced, mdeb, $time);
            end
            checks++;
            if (evt_valid !== (mq.size() > 0)) begin
                errors++; $display("FAIL model_valid got=%b exp=%0d t=%0t", evt_valid, mq.size() > 0, $time);
            end
            if (mq.size() > 0) begin
                checks++;
                if ({evt_btn, evt_press} !== mq[0]) begin
                    errors++; $display("FAIL model_head got=%b exp=%b t=%0t", {evt_btn, evt_press}, mq[0], $time);
                end
            end
            checks++;
            if (evt_overflow !== mov) begin
                errors++; $display("FAIL model_overflow got=%b exp=%b t=%0t", evt_overflow, mov, $time);
            end
        end
    end

    ev_t log_q [$];
    int  ovf_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (evt_valid && evt_ready) log_q.push_back({evt_btn, evt_press});
            if (evt_overflow) ovf_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        int n;
        noisy = 4'hf; evt_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({debounced, evt_valid, evt_btn, evt_press, evt_overflow} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0", {debounced, evt_valid, evt_btn, evt_press, evt_overflow});
        end
        #1 reset_n = 1'b1;
        log_q.delete();
        n = 0;
        while (debounced !== 4'hf && n < 60) begin step(1); n++; end
        checks++;
        if (n < 33 || n > 47) begin
            errors++; $display("FAIL reset_redetect_latency got=%0d exp=33..47", n);
        end
        step(4);
        checks++;
        if (log_q.size() != 4) begin
            errors++; $display("FAIL reset_event_count got=%0d exp=4", log_q.size());
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== {2'(i), 1'b1}) begin
                errors++; $display("FAIL reset_event_order idx=%0d got=%b exp=%b", i, log_q[i], {2'(i), 1'b1});
            end
        end
    endtask

    task automatic test_clean_press_release;
        int n;
        noisy = '0; step(60);
        log_q.delete();
        noisy[2] = 1'b1;
        n = 0;
        while (!debounced[2] && n < 60) begin step(1); n++; end
        checks++;
        if (n < 33 || n > 47 || debounced !== 4'b0100) begin
            errors++; $display("FAIL clean_press latency=%0d deb=%b exp=33..47/0100", n, debounced);
        end
        step(100 - n);
        noisy[2] = 1'b0;
        n = 0;
        while (debounced[2] && n < 60) begin step(1); n++; end
        checks++;
        if (n < 33 || n > 47) begin
            errors++; $display("FAIL clean_release latency=%0d exp=33..47", n);
        end
        step(3);
        checks++;
        if (log_q.size() != 2 || log_q[0] !== {2'd2, 1'b1} || log_q[1] !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL clean_events got_n=%0d exp=2 entries {2,1},{2,0}", log_q.size());
        end
    endtask

    task automatic test_bounce;
        int n;
        log_q.delete();
        for (int k = 0; k < 6; k++) begin
            noisy[0] = ~noisy[0];
            step(15);
            checks++;
            if (debounced[0] !== 1'b0) begin
                errors++; $display("FAIL bounce_level toggle=%0d got=%b exp=0", k, debounced[0]);
            end
        end
        checks++;
        if (log_q.size() != 0) begin
            errors++; $display("FAIL bounce_no_event got=%0d exp=0", log_q.size());
        end
        noisy[0] = 1'b1;
        n = 0;
        while (!debounced[0] && n < 60) begin step(1); n++; end
        checks++;
        if (n > 47) begin
            errors++; $display("FAIL bounce_accept latency=%0d exp<=47", n);
        end
        step(3);
        checks++;
        if (log_q.size() != 1 || log_q[0] !== {2'd0, 1'b1}) begin
            errors++; $display("FAIL bounce_event got_n=%0d exp=1 entry {0,1}", log_q.size());
        end
    endtask

    task automatic test_overflow;
        ev_t exp_q [4];
        exp_q = '{{2'd0, 1'b0}, {2'd1, 1'b1}, {2'd2, 1'b1}, {2'd0, 1'b1}};
        evt_ready = 1'b0; log_q.delete(); ovf_cnt = 0;
        noisy = 4'b0110; step(50);
        noisy = 4'b0001; step(50);
        checks++;
        if (ovf_cnt != 2) begin
            errors++; $display("FAIL overflow_pulses got=%0d exp=2", ovf_cnt);
        end
        checks++;
        if (debounced !== 4'b0001 || evt_valid !== 1'b1) begin
            errors++; $display("FAIL overflow_state deb=%b valid=%b exp=0001/1", debounced, evt_valid);
        end
        evt_ready = 1'b1;
        step(4);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL overflow_drain_valid got=%b exp=0", evt_valid);
        end
        checks++;
        if (log_q.size() != 4) begin
            errors++; $display("FAIL overflow_drain_count got=%0d exp=4", log_q.size());
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL overflow_order idx=%0d got=%b exp=%b", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_full_pop;
        int n;
        ev_t exp_q [5];
        exp_q = '{{2'd0, 1'b0}, {2'd1, 1'b1}, {2'd2, 1'b1}, {2'd3, 1'b1}, {2'd0, 1'b1}};
        evt_ready = 1'b0; log_q.delete(); ovf_cnt = 0;
        noisy = 4'b1110; step(50);
        noisy = 4'b1111;
        n = 0;
        while (!(e % T == 0 && ms2[0] != mdeb[0] && mcnt[0] == S - 1) && n < 80) begin step(1); n++; end
        checks++;
        if (n >= 80) begin
            errors++; $display("FAIL fullpop_wait timeout got=%0d exp<80", n);
        end
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (evt_overflow !== 1'b0 || debounced !== 4'hf) begin
            errors++; $display("FAIL fullpop_no_overflow ovf=%b deb=%b exp=0/1111", evt_overflow, debounced);
        end
        step(1);
        evt_ready = 1'b1;
        step(6);
        checks++;
        if (log_q.size() != 5 || ovf_cnt != 0) begin
            errors++; $display("FAIL fullpop_count got=%0d ovf=%0d exp=5/0", log_q.size(), ovf_cnt);
        end
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL fullpop_order idx=%0d got=%b exp=%b", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int len;
        repeat (300) begin
            noisy = 4'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 70);
            repeat (len) begin
                step(1);
                if ($urandom_range(0, 7) == 0) evt_ready = ~evt_ready;
                if ($urandom_range(0, 15) == 0) noisy[$urandom_range(0, N - 1)] ^= 1'b1;
            end
        end
        evt_ready = 1'b1;
        step(60);
        checks++;
        if (debounced !== noisy || evt_valid !== 1'b0) begin
            errors++; $display("FAIL random_settle deb=%b noisy=%b valid=%b", debounced, noisy, evt_valid);
        end
    endtask

    task automatic test_reset_midcount;
        int n;
        evt_ready = 1'b1;
        noisy = '0; step(60);
        log_q.delete();
        noisy[1] = 1'b1;
        step(25);
        reset_n = 1'b0;
        #1;
        checks++;
        if (debounced !== 4'b0 || evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_clear deb=%b valid=%b ovf=%b exp=0", debounced, evt_valid, evt_overflow);
        end
        #1 reset_n = 1'b1;
        n = 0;
        while (!debounced[1] && n < 60) begin step(1); n++; end
        checks++;
        if (n < 33 || n > 47) begin
            errors++; $display("FAIL midreset_redetect latency=%0d exp=33..47", n);
        end
        step(3);
        checks++;
        if (log_q.size() != 1 || log_q[0] !== {2'd1, 1'b1}) begin
            errors++; $display("FAIL midreset_event got_n=%0d exp=1 entry {1,1}", log_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press_release();
        test_bounce();
        test_overflow();
        test_full_pop();
        test_random();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
